// File: rtl/id_ex_stage_if.sv
// ID->EX bundle: decode-side inputs and registered EX-side outputs.
// The decode side drives id_*, the stage drives ex_*.
interface id_ex_stage_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   logic              id_valid;
   logic              id_RegWrite;
   logic              id_RegDst;
   logic              id_ALUSrc;
   logic              id_Branch;
   logic              id_MemWrite;
   logic              id_MemtoReg;
   logic              id_jump;
   logic [3:0]        id_ALUControl;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic [REG_AW-1:0] id_rd;
   logic [DATA_W-1:0] id_rd1;
   logic [DATA_W-1:0] id_rd2;
   logic [DATA_W-1:0] id_imm;
   logic [DATA_W-1:0] id_pc4;

   logic              ex_valid;
   logic              ex_RegWrite;
   logic              ex_RegDst;
   logic              ex_ALUSrc;
   logic              ex_Branch;
   logic              ex_MemWrite;
   logic              ex_MemtoReg;
   logic              ex_jump;
   logic [3:0]        ex_ALUControl;
   logic [REG_AW-1:0] ex_rs;
   logic [REG_AW-1:0] ex_rt;
   logic [REG_AW-1:0] ex_rd;
   logic [REG_AW-1:0] ex_wreg;
   logic [DATA_W-1:0] ex_rd1;
   logic [DATA_W-1:0] ex_rd2;
   logic [DATA_W-1:0] ex_imm;
   logic [DATA_W-1:0] ex_pc4;

   modport master (
      output id_valid, id_RegWrite, id_RegDst, id_ALUSrc,
      output id_Branch, id_MemWrite, id_MemtoReg, id_jump,
      output id_ALUControl, id_rs, id_rt, id_rd,
      output id_rd1, id_rd2, id_imm, id_pc4,
      input  ex_valid, ex_RegWrite, ex_RegDst, ex_ALUSrc,
      input  ex_Branch, ex_MemWrite, ex_MemtoReg, ex_jump,
      input  ex_ALUControl, ex_rs, ex_rt, ex_rd, ex_wreg,
      input  ex_rd1, ex_rd2, ex_imm, ex_pc4
   );

   modport slave (
      input  id_valid, id_RegWrite, id_RegDst, id_ALUSrc,
      input  id_Branch, id_MemWrite, id_MemtoReg, id_jump,
      input  id_ALUControl, id_rs, id_rt, id_rd,
      input  id_rd1, id_rd2, id_imm, id_pc4,
      output ex_valid, ex_RegWrite, ex_RegDst, ex_ALUSrc,
      output ex_Branch, ex_MemWrite, ex_MemtoReg, ex_jump,
      output ex_ALUControl, ex_rs, ex_rt, ex_rd, ex_wreg,
      output ex_rd1, ex_rd2, ex_imm, ex_pc4
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use hazard detection,
// bubble insertion, flush/stall handling and a bubble counter.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   id_ex_stage_if.slave     bus,
   input  logic             flush,
   input  logic             ex_stall,
   output logic             hazard_stall,
   output logic             load_use,
   output logic [CNT_W-1:0] bubble_cnt
);

   typedef struct packed {
      logic              valid;
      logic              regwrite;
      logic              regdst;
      logic              alusrc;
      logic              branch;
      logic              memwrite;
      logic              memtoreg;
      logic              jump;
      logic [3:0]        aluc;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] wreg;
      logic [DATA_W-1:0] rd1;
      logic [DATA_W-1:0] rd2;
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] pc4;
   } id_ex_t;

   id_ex_t            cur;
   id_ex_t            nxt;
   logic              uses_rt;
   logic              hit_rs;
   logic              hit_rt;
   logic              sel_bub;
   logic              sel_hold;
   logic              sel_cap;
   logic              bump;
   logic [REG_AW-1:0] wreg_d;

   assign uses_rt = bus.id_RegDst | bus.id_MemWrite
                  | bus.id_Branch;
   assign wreg_d  = bus.id_RegDst ? bus.id_rd : bus.id_rt;

   assign hit_rs  = cur.wreg == bus.id_rs;
   assign hit_rt  = uses_rt & (cur.wreg == bus.id_rt);

   assign load_use = bus.id_valid & cur.valid
                   & cur.memtoreg & cur.regwrite
                   & (cur.wreg != '0)
                   & (hit_rs | hit_rt);

   assign hazard_stall = ex_stall | (load_use & ~flush);

   // Mutually exclusive update selects, flush highest priority.
   assign sel_bub  = flush
                   | (~ex_stall & (load_use | ~bus.id_valid));
   assign sel_hold = ~flush & ex_stall;
   assign sel_cap  = ~flush & ~ex_stall & ~load_use
                   & bus.id_valid;

   assign bump = ~flush & ~ex_stall & load_use;

   // Next EX contents: bubble, hold or capture the decode slot.
   always_comb begin
      nxt = cur;
      unique case (1'b1)
         sel_bub: begin
            nxt.valid    = 1'b0;
            nxt.regwrite = 1'b0;
            nxt.memwrite = 1'b0;
            nxt.memtoreg = 1'b0;
            nxt.branch   = 1'b0;
            nxt.jump     = 1'b0;
         end
         sel_hold: nxt = cur;
         sel_cap: begin
            nxt.valid    = 1'b1;
            nxt.regwrite = bus.id_RegWrite;
            nxt.regdst   = bus.id_RegDst;
            nxt.alusrc   = bus.id_ALUSrc;
            nxt.branch   = bus.id_Branch;
            nxt.memwrite = bus.id_MemWrite;
            nxt.memtoreg = bus.id_MemtoReg;
            nxt.jump     = bus.id_jump;
            nxt.aluc     = bus.id_ALUControl;
            nxt.rs       = bus.id_rs;
            nxt.rt       = bus.id_rt;
            nxt.rd       = bus.id_rd;
            nxt.wreg     = wreg_d;
            nxt.rd1      = bus.id_rd1;
            nxt.rd2      = bus.id_rd2;
            nxt.imm      = bus.id_imm;
            nxt.pc4      = bus.id_pc4;
         end
         default: nxt = cur;
      endcase
   end

   // EX register; reset discards the slot at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur <= '0;
      end else begin
         cur <= nxt;
      end
   end

   // Saturating count of load-use bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt <= '0;
      end else if (bump && !(&bubble_cnt)) begin
         bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end

   assign bus.ex_valid      = cur.valid;
   assign bus.ex_RegWrite   = cur.regwrite;
   assign bus.ex_RegDst     = cur.regdst;
   assign bus.ex_ALUSrc     = cur.alusrc;
   assign bus.ex_Branch     = cur.branch;
   assign bus.ex_MemWrite   = cur.memwrite;
   assign bus.ex_MemtoReg   = cur.memtoreg;
   assign bus.ex_jump       = cur.jump;
   assign bus.ex_ALUControl = cur.aluc;
   assign bus.ex_rs         = cur.rs;
   assign bus.ex_rt         = cur.rt;
   assign bus.ex_rd         = cur.rd;
   assign bus.ex_wreg       = cur.wreg;
   assign bus.ex_rd1        = cur.rd1;
   assign bus.ex_rd2        = cur.rd2;
   assign bus.ex_imm        = cur.imm;
   assign bus.ex_pc4        = cur.pc4;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed instruction
// vectors, expected captures queued and checked by a monitor.
module tb_id_ex_stage;

   localparam int CW = 4;

   typedef struct packed {
      logic        valid;
      logic        regwrite;
      logic        regdst;
      logic        alusrc;
      logic        branch;
      logic        memwrite;
      logic        memtoreg;
      logic        jump;
      logic [3:0]  aluc;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] pc4;
   } ins_t;

   typedef struct packed {
      ins_t       ins;
      logic [4:0] wreg;
   } exp_t;

   localparam logic [7:0] C_LW   = 8'b1101_0010;
   localparam logic [7:0] C_ADD  = 8'b1110_0000;
   localparam logic [7:0] C_ADDI = 8'b1101_0000;
   localparam logic [7:0] C_SW   = 8'b1001_0100;
   localparam logic [7:0] C_BEQ  = 8'b1000_1000;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic          ex_stall;
   logic          hazard_stall;
   logic          load_use;
   logic [CW-1:0] bubble_cnt;

   int   checks;
   int   errors;
   exp_t q[$];

   id_ex_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

   id_ex_stage #(
      .DATA_W(32),
      .REG_AW(5),
      .CNT_W (CW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .flush       (flush),
      .ex_stall    (ex_stall),
      .hazard_stall(hazard_stall),
      .load_use    (load_use),
      .bubble_cnt  (bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic ins_t mk(
      logic [7:0] c, logic [3:0] a,
      logic [4:0] s, logic [4:0] t, logic [4:0] d,
      logic [31:0] b);
      ins_t r;
      {r.valid, r.regwrite, r.regdst, r.alusrc,
       r.branch, r.memwrite, r.memtoreg, r.jump} = c;
      r.aluc = a;
      r.rs   = s;
      r.rt   = t;
      r.rd   = d;
      r.rd1  = b + 32'd1;
      r.rd2  = b + 32'd2;
      r.imm  = b + 32'd3;
      r.pc4  = b + 32'd4;
      return r;
   endfunction

   task automatic drive(input ins_t i);
      bus.id_valid      = i.valid;
      bus.id_RegWrite   = i.regwrite;
      bus.id_RegDst     = i.regdst;
      bus.id_ALUSrc     = i.alusrc;
      bus.id_Branch     = i.branch;
      bus.id_MemWrite   = i.memwrite;
      bus.id_MemtoReg   = i.memtoreg;
      bus.id_jump       = i.jump;
      bus.id_ALUControl = i.aluc;
      bus.id_rs         = i.rs;
      bus.id_rt         = i.rt;
      bus.id_rd         = i.rd;
      bus.id_rd1        = i.rd1;
      bus.id_rd2        = i.rd2;
      bus.id_imm        = i.imm;
      bus.id_pc4        = i.pc4;
   endtask

   task automatic check(input string n,
                        input logic [31:0] a,
                        input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got=%h want=%h", n, a, e);
      end
   endtask

   task automatic push(input ins_t i, input logic [4:0] w);
      exp_t x;
      x.ins  = i;
      x.wreg = w;
      q.push_back(x);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      drive('0);
      flush    = 1'b0;
      ex_stall = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   // Monitor: compare each freshly captured valid slot.
   initial begin
      logic fresh;
      ins_t act;
      exp_t x;
      forever begin
         @(posedge clk);
         fresh = !ex_stall && rst_n;
         @(negedge clk);
         if (rst_n && bus.ex_valid && fresh) begin
            act = {bus.ex_valid, bus.ex_RegWrite,
                   bus.ex_RegDst, bus.ex_ALUSrc,
                   bus.ex_Branch, bus.ex_MemWrite,
                   bus.ex_MemtoReg, bus.ex_jump,
                   bus.ex_ALUControl, bus.ex_rs,
                   bus.ex_rt, bus.ex_rd, bus.ex_rd1,
                   bus.ex_rd2, bus.ex_imm, bus.ex_pc4};
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_capture got=%h", act);
            end else begin
               x = q.pop_front();
               if (act !== x.ins) begin
                  errors++;
                  $display("FAIL ex_bundle got=%h want=%h",
                           act, x.ins);
               end
               checks++;
               if (bus.ex_wreg !== x.wreg) begin
                  errors++;
                  $display("FAIL ex_wreg got=%0d want=%0d",
                           bus.ex_wreg, x.wreg);
               end
            end
         end
      end
   end

   initial begin
      ins_t lw2, add3, lw0, add0, lw5, addi5, addrt;
      ins_t sw8, beq, exp_n;
      int   e;
      checks = 0;
      errors = 0;
      lw2   = mk(C_LW,   4'b0010, 5'd1, 5'd2, 5'd0,
                 32'h1000_0000);
      add3  = mk(C_ADD,  4'b0010, 5'd2, 5'd4, 5'd3,
                 32'h2000_0000);
      lw0   = mk(C_LW,   4'b0010, 5'd1, 5'd0, 5'd0,
                 32'h3000_0000);
      add0  = mk(C_ADD,  4'b0010, 5'd0, 5'd4, 5'd3,
                 32'h4000_0000);
      lw5   = mk(C_LW,   4'b0010, 5'd1, 5'd5, 5'd0,
                 32'h5000_0000);
      addi5 = mk(C_ADDI, 4'b0010, 5'd7, 5'd5, 5'd6,
                 32'h6000_0000);
      addrt = mk(C_ADD,  4'b0010, 5'd7, 5'd5, 5'd6,
                 32'h6100_0000);
      sw8   = mk(C_SW,   4'b0010, 5'd9, 5'd8, 5'd0,
                 32'h7000_0000);
      beq   = mk(C_BEQ,  4'b0110, 5'd2, 5'd9, 5'd0,
                 32'h8000_0000);

      rst_n    = 1'b0;
      flush    = 1'b0;
      ex_stall = 1'b0;
      drive('0);
      #1;
      check("rst_ex_valid", 32'(bus.ex_valid), 0);
      check("rst_ex_wreg", 32'(bus.ex_wreg), 0);
      check("rst_ex_aluc", 32'(bus.ex_ALUControl), 0);
      check("rst_ex_pc4", bus.ex_pc4, 0);
      check("rst_bubble_cnt", 32'(bubble_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // lw $2 ; add $3,$2,$4 -> one bubble
      drive(lw2);
      #1;
      check("t1_no_lu_first", 32'(load_use), 0);
      push(lw2, 5'd2);
      tick();
      drive(add3);
      #1;
      check("t1_load_use", 32'(load_use), 1);
      check("t1_hazard", 32'(hazard_stall), 1);
      tick();
      check("t1_bubble_valid", 32'(bus.ex_valid), 0);
      check("t1_bubble_cnt", 32'(bubble_cnt), 1);
      check("t1_lu_drops", 32'(load_use), 0);
      check("t1_hazard_drops", 32'(hazard_stall), 0);
      push(add3, 5'd3);
      tick();
      drive('0);
      tick();

      // lw $0 ; add $3,$0,$4 -> no hazard
      do_reset();
      drive(lw0);
      push(lw0, 5'd0);
      tick();
      drive(add0);
      #1;
      check("t2_load_use", 32'(load_use), 0);
      check("t2_hazard", 32'(hazard_stall), 0);
      push(add0, 5'd3);
      tick();
      drive('0);
      check("t2_bubble_cnt", 32'(bubble_cnt), 0);
      tick();

      // lw $5 ; addi rt=5 (no rt use) ; then add rt=5
      do_reset();
      drive(lw5);
      push(lw5, 5'd5);
      tick();
      drive(addi5);
      #1;
      check("t3_addi_lu", 32'(load_use), 0);
      push(addi5, 5'd5);
      tick();
      drive(lw5);
      push(lw5, 5'd5);
      tick();
      drive(addrt);
      #1;
      check("t3_rt_lu", 32'(load_use), 1);
      tick();
      push(addrt, 5'd6);
      tick();
      drive('0);
      check("t3_bubble_cnt", 32'(bubble_cnt), 1);
      tick();

      // sw held by ex_stall, flush mid-stall
      do_reset();
      drive(sw8);
      push(sw8, 5'd8);
      tick();
      ex_stall = 1'b1;
      drive(add3);
      #1;
      check("t4_hz_c1", 32'(hazard_stall), 1);
      tick();
      check("t4_hold_valid", 32'(bus.ex_valid), 1);
      check("t4_hold_rd1", bus.ex_rd1, sw8.rd1);
      check("t4_hold_mw", 32'(bus.ex_MemWrite), 1);
      flush = 1'b1;
      #1;
      check("t4_hz_c2", 32'(hazard_stall), 1);
      tick();
      flush = 1'b0;
      check("t4_flush_valid", 32'(bus.ex_valid), 0);
      check("t4_flush_mw", 32'(bus.ex_MemWrite), 0);
      check("t4_flush_rd1", bus.ex_rd1, sw8.rd1);
      #1;
      check("t4_hz_c3", 32'(hazard_stall), 1);
      tick();
      check("t4_still_bubble", 32'(bus.ex_valid), 0);
      ex_stall = 1'b0;
      push(add3, 5'd3);
      tick();
      drive('0);
      tick();

      // lw $2 ; beq $2,$9 killed by flush
      do_reset();
      drive(lw2);
      push(lw2, 5'd2);
      tick();
      drive(beq);
      flush = 1'b1;
      #1;
      check("t5_load_use", 32'(load_use), 1);
      check("t5_hazard", 32'(hazard_stall), 0);
      tick();
      flush = 1'b0;
      drive('0);
      check("t5_valid", 32'(bus.ex_valid), 0);
      check("t5_bubble_cnt", 32'(bubble_cnt), 0);
      tick();

      // counter saturation, then mid-cycle reset
      do_reset();
      for (int i = 0; i < 17; i++) begin
         drive(lw2);
         push(lw2, 5'd2);
         tick();
         drive(add3);
         tick();
         e = (i + 1 > 15) ? 15 : i + 1;
         check($sformatf("t6_cnt_%0d", i),
               32'(bubble_cnt), e);
      end
      drive(lw2);
      push(lw2, 5'd2);
      tick();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 32'(bus.ex_valid), 0);
      check("t6_rst_wreg", 32'(bus.ex_wreg), 0);
      check("t6_rst_rd1", bus.ex_rd1, 0);
      check("t6_rst_m2r", 32'(bus.ex_MemtoReg), 0);
      check("t6_rst_aluc", 32'(bus.ex_ALUControl), 0);
      check("t6_rst_cnt", 32'(bubble_cnt), 0);
      check("t6_rst_lu", 32'(load_use), 0);
      exp_n = add3;
      drive(exp_n);
      #1;
      rst_n = 1'b1;
      push(exp_n, 5'd3);
      tick();
      check("t6_after_rst", 32'(bus.ex_valid), 1);
      drive('0);
      tick();
      tick();

      check("queue_empty", 32'(q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
